// File: rtl/rtc_init_sequencer_pkg.sv
// Shared definitions for the selector-mux control stages: FSM encoding,
// selector table indices and default pair count.
package rtc_init_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL_DIR  = 3'd1,
        ST_CAP_DIR  = 3'd2,
        ST_CAP_DATO = 3'd3,
        ST_WR_REQ   = 3'd4,
        ST_WR_WAIT  = 3'd5,
        ST_NEXT     = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    localparam logic [7:0] IDX_LISTO         = 8'd1;
    localparam logic [7:0] IDX_LISTO_ESCRIBE = 8'd2;
    localparam logic [7:0] IDX_LISTO_LEE     = 8'd3;
    localparam logic [7:0] IDX_TABLA         = 8'd4;

    localparam int N_PARES_DEF = 3;

endpackage

// File: rtl/rtc_init_sequencer_if.sv
// Handshake bundle between the init sequencer (master) and its surroundings:
// selector mux, write engine and the controller above.
interface rtc_init_sequencer_if
    import rtc_init_sequencer_pkg::*;
;
    logic       inicio;
    logic [7:0] dato_mux;
    logic       listo_escribe;
    logic [7:0] seleccion;
    logic [7:0] dir_out;
    logic [7:0] dato_out;
    logic       escribe;
    logic       ocupado;
    logic       fin;
    logic       error_to;

    modport master (
        input  inicio, dato_mux, listo_escribe,
        output seleccion, dir_out, dato_out, escribe, ocupado, fin, error_to
    );

    modport slave (
        output inicio, dato_mux, listo_escribe,
        input  seleccion, dir_out, dato_out, escribe, ocupado, fin, error_to
    );

endinterface

// File: rtl/rtc_wait_timer.sv
// Loadable down-counter; o_expired flags the last enabled cycle of a wait
// window of i_load_val cycles.
module rtc_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loaded with N, the counter reads 1 in the N-th enabled cycle.
    assign o_expired = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/rtc_init_sequencer.sv
// Walks the address/data init table through the selector mux and issues one
// write-engine transaction per pair, reporting fin or a sticky timeout.
module rtc_init_sequencer
    import rtc_init_sequencer_pkg::*;
#(
    parameter int IDX_INICIO  = 4,
    parameter int N_PARES     = N_PARES_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_init_sequencer_if.master bus
);

    localparam logic [7:0] LAST_PAIR = 8'(N_PARES - 1);

    state_t     r_state, w_state_next;
    logic [7:0] r_idx, w_idx_next;
    logic [7:0] r_pair, w_pair_next;
    logic [7:0] r_sel, w_sel_next;
    logic [7:0] r_dir, w_dir_next;
    logic [7:0] r_dato, w_dato_next;
    logic       r_err, w_err_next;
    logic       r_first;
    logic       r_escribe, r_ocupado, r_fin;
    logic       w_expired;
    logic       w_listo_ok;

    // The first WR_WAIT cycle may still see the previous transaction's flag.
    assign w_listo_ok = bus.listo_escribe && !r_first;

    rtc_wait_timer #(.W(8)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state == ST_WR_REQ),
        .i_load_val (8'(TIMEOUT_CYC)),
        .i_en       (r_state == ST_WR_WAIT),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pair    <= '0;
            r_sel     <= '0;
            r_dir     <= '0;
            r_dato    <= '0;
            r_err     <= 1'b0;
            r_first   <= 1'b0;
            r_escribe <= 1'b0;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_pair    <= w_pair_next;
            r_sel     <= w_sel_next;
            r_dir     <= w_dir_next;
            r_dato    <= w_dato_next;
            r_err     <= w_err_next;
            r_first   <= (r_state == ST_WR_REQ);
            r_escribe <= (w_state_next == ST_WR_REQ);
            r_ocupado <= (w_state_next != ST_IDLE);
            r_fin     <= (w_state_next == ST_DONE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (bus.inicio) w_state_next = ST_SEL_DIR;
            ST_SEL_DIR:  w_state_next = ST_CAP_DIR;
            ST_CAP_DIR:  w_state_next = ST_CAP_DATO;
            ST_CAP_DATO: w_state_next = ST_WR_REQ;
            ST_WR_REQ:   w_state_next = ST_WR_WAIT;
            // Completion takes priority over a timeout in the same cycle.
            ST_WR_WAIT: begin
                if (w_listo_ok)     w_state_next = ST_NEXT;
                else if (w_expired) w_state_next = ST_IDLE;
            end
            ST_NEXT:     w_state_next = (r_pair == LAST_PAIR) ? ST_DONE : ST_SEL_DIR;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idx_next  = r_idx;
        w_pair_next = r_pair;
        w_sel_next  = r_sel;
        w_dir_next  = r_dir;
        w_dato_next = r_dato;
        w_err_next  = r_err;
        case (r_state)
            ST_IDLE: begin
                w_sel_next = '0;
                if (bus.inicio) begin
                    w_err_next  = 1'b0;
                    w_idx_next  = 8'(IDX_INICIO);
                    w_pair_next = '0;
                end
            end
            ST_SEL_DIR:  w_sel_next = r_idx;
            ST_CAP_DIR: begin
                w_dir_next = bus.dato_mux;
                w_sel_next = r_idx + 8'd1;
            end
            ST_CAP_DATO: w_dato_next = bus.dato_mux;
            ST_WR_WAIT: begin
                if (!w_listo_ok && w_expired) begin
                    w_err_next = 1'b1;
                    w_sel_next = '0;
                end
            end
            ST_NEXT: begin
                w_idx_next  = r_idx + 8'd2;
                w_pair_next = r_pair + 8'd1;
            end
            ST_DONE:     w_sel_next = '0;
            default:     ;
        endcase
    end

    assign bus.seleccion = r_sel;
    assign bus.dir_out   = r_dir;
    assign bus.dato_out  = r_dato;
    assign bus.escribe   = r_escribe;
    assign bus.ocupado   = r_ocupado;
    assign bus.fin       = r_fin;
    assign bus.error_to  = r_err;

endmodule
